// File: rtl/spi_slave_regfile.sv
// -----------------------------------------------------------------------------
// spi_slave_regfile
//
// SPI target-side register responder. It oversamples spi_clk / sl / mosi in
// the clk40M domain and decodes 40-bit frames of the form
// cmd[7:0], addr[15:0], data[15:0] (MSB first) against a local bank of
// 2**ADDR_W 16-bit registers.
//   cmd 0x01 : WRITE. An in-range address updates the bank and pulses wr_valid.
//   cmd 0x02 : READ. Only recognised when SPI_SLV_READBACK_EN is defined; it
//              returns reg[addr] on miso during bits 24..39.
//   other    : the frame is rejected and err_cnt increments (saturating).
// A frame that ends (sl rises) before 40 bits is aborted and also counted.
//
// Build option: define SPI_SLV_READBACK_EN to build the miso read path.
// Without it, miso is tied low and cmd 0x02 counts as an invalid command.
//
// Ports
//   clk40M   in   sole clock, rising edge
//   rst      in   synchronous active-high reset
//   spi_clk  in   SPI clock (mode 0, idle low), asynchronous
//   sl       in   chip select, active low, asynchronous
//   mosi     in   serial data in, MSB first
//   miso     out  serial data out, registered
//   wr_valid out  one-cycle pulse per committed write
//   wr_addr  out  address of the last committed write
//   wr_data  out  data of the last committed write
//   err_cnt  out  saturating count of rejected frames
// -----------------------------------------------------------------------------
module spi_slave_regfile #(
    parameter int ADDR_W = 8,
    parameter int ERR_W  = 8
) (
    input  logic              clk40M,
    input  logic              rst,
    input  logic              spi_clk,
    input  logic              sl,
    input  logic              mosi,
    output logic              miso,
    output logic              wr_valid,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [15:0]       wr_data,
    output logic [ERR_W-1:0]  err_cnt
);

    localparam int DEPTH = 1 << ADDR_W;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SHIFT  = 2'd1;
    localparam logic [1:0] ST_COMMIT = 2'd2;
    localparam logic [1:0] ST_ABORT  = 2'd3;

    localparam logic [5:0] FRAME_BITS    = 6'd40;
    localparam logic [5:0] READ_LOAD_BIT = 6'd24;
    localparam logic [7:0] CMD_WRITE     = 8'h01;
    localparam logic [7:0] CMD_READ      = 8'h02;

`ifdef SPI_SLV_READBACK_EN
    localparam logic READBACK_EN = 1'b1;
`else
    localparam logic READBACK_EN = 1'b0;
`endif

    // An address is in range when no bit at or above ADDR_W is set.
    function automatic logic addr_in_range(input logic [15:0] addr);
        return (addr >> ADDR_W) == 16'd0;
    endfunction

    // Increment that sticks at all-ones.
    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        if (v == {ERR_W{1'b1}}) begin
            return v;
        end else begin
            return v + {{(ERR_W-1){1'b0}}, 1'b1};
        end
    endfunction

    // Synchronizers and edge strobes
    logic [2:0] sclk_sync_q, sclk_sync_d;
    logic [2:0] sl_sync_q,   sl_sync_d;
    logic [1:0] mosi_sync_q, mosi_sync_d;
    logic       sclk_rise_q, sclk_rise_d;
    logic       sclk_fall_q, sclk_fall_d;
    logic       sl_rise_q,   sl_rise_d;
    logic       sl_fall_q,   sl_fall_d;

    // Frame engine
    logic [1:0]        state_q,    state_d;
    logic [5:0]        bit_cnt_q,  bit_cnt_d;
    logic [39:0]       shift_q,    shift_d;
    logic [ERR_W-1:0]  err_cnt_q,  err_cnt_d;
    logic              wr_valid_q, wr_valid_d;
    logic [ADDR_W-1:0] wr_addr_q,  wr_addr_d;
    logic [15:0]       wr_data_q,  wr_data_d;
    logic              mem_we_s;
    logic              sl_low_s;

    logic [7:0]  cmd_s;
    logic [15:0] addr_s;
    logic [15:0] data_s;

    logic [15:0] mem_q [DEPTH];

    assign cmd_s    = shift_q[39:32];
    assign addr_s   = shift_q[31:16];
    assign data_s   = shift_q[15:0];
    // Synchronized chip-select level, aligned with the registered strobes.
    assign sl_low_s = ~sl_sync_q[2];

    // Next-state for the synchronizer chains and edge strobes.
    always_comb begin
        sclk_sync_d = {sclk_sync_q[1:0], spi_clk};
        sl_sync_d   = {sl_sync_q[1:0], sl};
        mosi_sync_d = {mosi_sync_q[0], mosi};
        sclk_rise_d =  sclk_sync_q[1] & ~sclk_sync_q[2];
        sclk_fall_d = ~sclk_sync_q[1] &  sclk_sync_q[2];
        sl_rise_d   =  sl_sync_q[1]   & ~sl_sync_q[2];
        sl_fall_d   = ~sl_sync_q[1]   &  sl_sync_q[2];
    end

    // Synchronizer and strobe flops. Reset to 0 so that a reset taken while
    // sl is low can never fabricate a falling strobe mid-frame.
    always_ff @(posedge clk40M) begin
        if (rst) begin
            sclk_sync_q <= 3'b000;
            sl_sync_q   <= 3'b000;
            mosi_sync_q <= 2'b00;
            sclk_rise_q <= 1'b0;
            sclk_fall_q <= 1'b0;
            sl_rise_q   <= 1'b0;
            sl_fall_q   <= 1'b0;
        end else begin
            sclk_sync_q <= sclk_sync_d;
            sl_sync_q   <= sl_sync_d;
            mosi_sync_q <= mosi_sync_d;
            sclk_rise_q <= sclk_rise_d;
            sclk_fall_q <= sclk_fall_d;
            sl_rise_q   <= sl_rise_d;
            sl_fall_q   <= sl_fall_d;
        end
    end

    // Bit capture, frame FSM and commit decisions.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        err_cnt_d  = err_cnt_q;
        wr_valid_d = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        mem_we_s   = 1'b0;

        // A new frame may start in the same cycle as COMMIT/ABORT; the commit
        // below still decodes the old shift_q because it reads the flop value.
        if (sl_fall_q) begin
            bit_cnt_d = 6'd0;
            shift_d   = 40'd0;
        end else if ((state_q == ST_SHIFT) && sclk_rise_q && sl_low_s &&
                     (bit_cnt_q < FRAME_BITS)) begin
            bit_cnt_d = bit_cnt_q + 6'd1;
            shift_d   = {shift_q[38:0], mosi_sync_q[1]};
        end else begin
            bit_cnt_d = bit_cnt_q;
            shift_d   = shift_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (sl_fall_q) begin
                    state_d = ST_SHIFT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (sl_rise_q) begin
                    if (bit_cnt_q == FRAME_BITS) begin
                        state_d = ST_COMMIT;
                    end else begin
                        state_d = ST_ABORT;
                    end
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            ST_COMMIT: begin
                if (cmd_s == CMD_WRITE) begin
                    // Out-of-range writes are dropped without counting.
                    if (addr_in_range(addr_s)) begin
                        mem_we_s   = 1'b1;
                        wr_valid_d = 1'b1;
                        wr_addr_d  = addr_s[ADDR_W-1:0];
                        wr_data_d  = data_s;
                    end else begin
                        mem_we_s   = 1'b0;
                    end
                end else if (READBACK_EN && (cmd_s == CMD_READ)) begin
                    err_cnt_d = err_cnt_q;
                end else begin
                    err_cnt_d = sat_inc(err_cnt_q);
                end
                if (sl_fall_q) begin
                    state_d = ST_SHIFT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ABORT: begin
                err_cnt_d = sat_inc(err_cnt_q);
                if (sl_fall_q) begin
                    state_d = ST_SHIFT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Frame engine and write-port flops.
    always_ff @(posedge clk40M) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= 6'd0;
            shift_q    <= 40'd0;
            err_cnt_q  <= {ERR_W{1'b0}};
            wr_valid_q <= 1'b0;
            wr_addr_q  <= {ADDR_W{1'b0}};
            wr_data_q  <= 16'h0000;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            err_cnt_q  <= err_cnt_d;
            wr_valid_q <= wr_valid_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
        end
    end

    // Register bank; the write lands together with the wr_valid pulse.
    always_ff @(posedge clk40M) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 16'h0000;
            end
        end else if (mem_we_s) begin
            mem_q[addr_s[ADDR_W-1:0]] <= data_s;
        end
    end

`ifdef SPI_SLV_READBACK_EN
    logic [15:0] out_sr_q, out_sr_d;
    logic        miso_q,   miso_d;
    logic [15:0] load_val_s;

    // Read data for the address just received (bits 15:0 of the 24 bits in).
    assign load_val_s = addr_in_range(shift_q[15:0]) ?
                        mem_q[shift_q[ADDR_W-1:0]] : 16'h0000;

    // Output shifter: load after bit 24, shift on each later spi_clk fall.
    // The synchronized sl level clears it early so miso idles within 3 cycles.
    always_comb begin
        out_sr_d = out_sr_q;
        miso_d   = miso_q;
        if (sl_sync_q[1]) begin
            out_sr_d = 16'h0000;
            miso_d   = 1'b0;
        end else if ((state_q == ST_SHIFT) && sclk_fall_q &&
                     (bit_cnt_q == READ_LOAD_BIT) &&
                     (shift_q[23:16] == CMD_READ)) begin
            out_sr_d = load_val_s;
            miso_d   = load_val_s[15];
        end else if (sclk_fall_q) begin
            out_sr_d = {out_sr_q[14:0], 1'b0};
            miso_d   = out_sr_q[14];
        end else begin
            out_sr_d = out_sr_q;
            miso_d   = miso_q;
        end
    end

    // Output shifter flops.
    always_ff @(posedge clk40M) begin
        if (rst) begin
            out_sr_q <= 16'h0000;
            miso_q   <= 1'b0;
        end else begin
            out_sr_q <= out_sr_d;
            miso_q   <= miso_d;
        end
    end

    assign miso = miso_q;
`else
    logic unused_s;

    // Nothing reads the bank or the falling strobe in this build; fold them
    // into a sink so they are visibly consumed.
    always_comb begin
        unused_s = sclk_fall_q;
        for (int i = 0; i < DEPTH; i++) begin
            unused_s = unused_s ^ (^mem_q[i]);
        end
    end

    assign miso = 1'b0;
`endif

    assign wr_valid = wr_valid_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_spi_slave_regfile.sv
// -----------------------------------------------------------------------------
// Self-checking bench for spi_slave_regfile. Frames are bit-banged on the SPI
// pins; a behavioural model (register array + counters) predicts write
// pulses, error count, write port values and miso read data per frame.
// -----------------------------------------------------------------------------
module tb_spi_slave_regfile;

    localparam int ADDR_W = 8;
    localparam int ERR_W  = 8;
    localparam int HALF   = 6;

`ifdef SPI_SLV_READBACK_EN
    localparam bit READBACK = 1'b1;
`else
    localparam bit READBACK = 1'b0;
`endif

    logic              clk40M = 1'b0;
    logic              rst;
    logic              spi_clk;
    logic              sl;
    logic              mosi;
    logic              miso;
    logic              wr_valid;
    logic [ADDR_W-1:0] wr_addr;
    logic [15:0]       wr_data;
    logic [ERR_W-1:0]  err_cnt;

    spi_slave_regfile #(.ADDR_W(ADDR_W), .ERR_W(ERR_W)) dut (
        .clk40M  (clk40M),
        .rst     (rst),
        .spi_clk (spi_clk),
        .sl      (sl),
        .mosi    (mosi),
        .miso    (miso),
        .wr_valid(wr_valid),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .err_cnt (err_cnt)
    );

    always #5 clk40M = ~clk40M;

    // Reference model state
    logic [15:0] model_mem [0:255];
    int          model_err;
    logic [7:0]  model_wr_addr;
    logic [15:0] model_wr_data;

    int checks = 0;
    int errors = 0;
    int wr_pulses = 0;

    // Count every cycle wr_valid is high.
    always @(posedge clk40M) begin
        if (wr_valid === 1'b1) wr_pulses <= wr_pulses + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk40M);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 256; i++) model_mem[i] = 16'h0000;
        model_err     = 0;
        model_wr_addr = 8'h00;
        model_wr_data = 16'h0000;
    endtask

    // Drive one frame of nbits clocks; pulse rst before bit rst_at (if >= 0).
    task automatic send_frame(input logic [39:0] f, input int nbits, input int rst_at,
                              output logic [15:0] rd, output int stray);
        rd    = 16'h0000;
        stray = 0;
        sl    = 1'b0;
        idle(HALF);
        for (int i = 0; i < nbits; i++) begin
            if (i == rst_at) begin
                rst = 1'b1;
                idle(1);
                rst = 1'b0;
            end
            mosi = (i < 40) ? f[39-i] : 1'($urandom);
            idle(HALF);
            if (i >= 24 && i < 40) rd[39-i] = miso;
            else if (miso !== 1'b0) stray++;
            spi_clk = 1'b1;
            idle(HALF);
            spi_clk = 1'b0;
        end
        idle(HALF);
        sl = 1'b1;
        idle(12);
    endtask

    // Predict the outcome of a frame, send it, and compare.
    task automatic run_frame(input logic [7:0] cmd, input logic [15:0] addr,
                             input logic [15:0] data, input int nbits, input int rst_at);
        logic [15:0] rd;
        logic [15:0] exp_rd;
        int          stray;
        int          p0;
        int          exp_pulses;

        exp_rd     = 16'h0000;
        exp_pulses = 0;
        if (rst_at >= 0 && rst_at < nbits) begin
            model_reset();
        end else if (nbits < 40) begin
            if (model_err < 255) model_err++;
        end else if (cmd == 8'h01) begin
            if (addr < 16'd256) begin
                model_mem[addr]  = data;
                model_wr_addr    = addr[7:0];
                model_wr_data    = data;
                exp_pulses       = 1;
            end
        end else if (cmd == 8'h02 && READBACK) begin
            exp_rd = (addr < 16'd256) ? model_mem[addr] : 16'h0000;
        end else begin
            if (model_err < 255) model_err++;
        end

        p0 = wr_pulses;
        send_frame({cmd, addr, data}, nbits, rst_at, rd, stray);
        check_eq("wr_pulses",  wr_pulses - p0, exp_pulses);
        check_eq("err_cnt",    err_cnt, model_err);
        check_eq("wr_addr",    wr_addr, model_wr_addr);
        check_eq("wr_data",    wr_data, model_wr_data);
        check_eq("miso_read",  rd, exp_rd);
        check_eq("miso_stray", stray, 0);
        check_eq("miso_idle",  miso, 1'b0);
    endtask

    // Hard stop if the run ever stalls.
    initial begin
        #800000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int kind;
        logic [7:0]  c;
        logic [15:0] a;

        rst     = 1'b1;
        sl      = 1'b1;
        spi_clk = 1'b0;
        mosi    = 1'b0;
        model_reset();
        idle(3);
        rst = 1'b0;
        idle(5);
        check_eq("rst_miso",     miso, 1'b0);
        check_eq("rst_wr_valid", wr_valid, 1'b0);
        check_eq("rst_wr_addr",  wr_addr, 8'h00);
        check_eq("rst_wr_data",  wr_data, 16'h0000);
        check_eq("rst_err_cnt",  err_cnt, 8'h00);

        // Directed scenarios
        run_frame(8'h01, 16'h0012, 16'hBEEF, 40, -1);
        run_frame(8'h02, 16'h0012, 16'h0000, 40, -1);
        run_frame(8'h01, 16'h0100, 16'h5555, 40, -1);
        run_frame(8'h02, 16'h0100, 16'h0000, 40, -1);
        run_frame(8'h01, 16'h0003, 16'h1111, 20, -1);
        run_frame(8'h7F, 16'h0003, 16'h2222, 40, -1);
        run_frame(8'h01, 16'h0001, 16'h1234, 45, -1);
        run_frame(8'h02, 16'h0001, 16'h0000, 40, -1);
        run_frame(8'h01, 16'h0020, 16'hCAFE, 40, 30);
        run_frame(8'h01, 16'h0005, 16'hA5A5, 40, -1);
        run_frame(8'h02, 16'h0005, 16'h0000, 40, -1);

        // Randomized mix
        for (int n = 0; n < 40; n++) begin
            kind = $urandom_range(0, 9);
            case (kind)
                0, 1, 2, 3: run_frame(8'h01, {8'h00, 8'($urandom_range(0, 7))}, 16'($urandom),
                                      $urandom_range(40, 44), -1);
                4, 5:       run_frame(8'h02, {8'h00, 8'($urandom_range(0, 7))}, 16'($urandom),
                                      $urandom_range(40, 44), -1);
                6: begin
                    a = 16'($urandom) | 16'h0100;
                    run_frame(8'h01, a, 16'($urandom), 40, -1);
                end
                7: begin
                    a = 16'($urandom) | 16'h0100;
                    run_frame(8'h02, a, 16'h0000, 40, -1);
                end
                8: begin
                    c = 8'h03 + 8'($urandom_range(0, 252));
                    run_frame(c, 16'($urandom), 16'($urandom), 40, -1);
                end
                default: run_frame(8'($urandom), 16'($urandom), 16'($urandom),
                                   $urandom_range(1, 24), -1);
            endcase
        end

        // Error counter saturation through repeated aborts
        run_frame(8'h01, 16'h0000, 16'h0000, 40, 10);
        for (int n = 0; n < 260; n++) begin
            run_frame(8'h01, 16'h0000, 16'h0000, 1, -1);
        end
        check_eq("err_sat", err_cnt, 8'hFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_slave_regfile.md
# spi_slave_regfile

SPI target-side register responder: the other end of the SPI master's cmd/addr/data frame. It samples `spi_clk`/`sl`/`mosi` inside the 40 MHz domain, decodes 40-bit write and read frames against a local bank of 16-bit registers, drives `miso` on reads, and pulses a write strobe to downstream sensor-model logic. It serves as the sensor-side model on the system bench and as the register port of an FPGA-emulated sensor.

## Interface
- `ADDR_W`, 8: register-bank address width; bank holds 2**ADDR_W 16-bit registers.
- `ERR_W`, 8: frame-error counter width.
- `clk40M` in 1: sole clock; all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `spi_clk` in 1: SPI clock from master, asynchronous; mode 0, idle low.
- `sl` in 1: chip select, active low, asynchronous.
- `mosi` in 1: serial data in, MSB first.
- `miso` out 1: serial data out, registered.
- `wr_valid` out 1: one-cycle pulse on committed write.
- `wr_addr` out ADDR_W: address of committed write, held until next write.
- `wr_data` out 16: data of committed write, held until next write.
- `err_cnt` out ERR_W: saturating count of rejected frames.

## Operation
- `spi_clk`, `sl`, `mosi` each pass a 2-flop synchronizer. A third flop on `spi_clk` and `sl` yields rise/fall strobes.
- Frame is 40 bits, MSB first: cmd[7:0], addrMsb, addrLsb, dataMsb, dataLsb.
- Bit counter is 6 bits. It clears on the `sl` falling strobe and increments on each `spi_clk` rising strobe while `sl` is low, saturating at 40.
- `mosi` is shifted into a 40-bit register on `spi_clk` rising strobes only while the counter is below 40. Bits beyond 40 are ignored.
- Commands: 0x01 is WRITE, 0x02 is READ. Any other cmd marks the frame invalid.
- Address decode: addresses with bits above ADDR_W-1 set are out of range.
- FSM states:
  - IDLE → SHIFT on `sl` fall.
  - SHIFT → COMMIT on `sl` rise with count==40.
  - SHIFT → ABORT on `sl` rise with count<40.
  - COMMIT → IDLE after one cycle.
  - ABORT → IDLE after one cycle.
- COMMIT with WRITE, in range: write reg[addr]; pulse `wr_valid`; update `wr_addr`/`wr_data`.
- COMMIT with WRITE, out of range: silently dropped; no pulse, no error.
- COMMIT with READ: no register change.
- COMMIT with invalid cmd: `err_cnt` +1.
- ABORT: no write; `err_cnt` +1.
- `err_cnt` saturates at all-ones.
- Read path:
  - On the `spi_clk` fall strobe after bit 24 has been sampled, with cmd==0x02, load a 16-bit output shift register. Load value is reg[addr], or 0x0000 if out of range.
  - `miso` takes bit 15 at load. Each later fall strobe shifts left one bit.
  - In all other cases `miso` drives 0.
- `sl` rising in any state returns `miso` to 0 within 3 cycles.

## Timing
- Reset values: `miso`=0, `wr_valid`=0, `wr_addr`=0, `wr_data`=0x0000, `err_cnt`=0, all registers 0x0000, FSM in IDLE, bit counter 0.
- Input-to-strobe latency: 3 `clk40M` cycles.
- `spi_clk` high and low phases must each be ≥4 `clk40M` cycles (`spi_clk` ≤5 MHz). Faster clocks are unsupported.
- `sl` must be high for ≥4 cycles between frames.
- Write latency: `wr_valid` and the register update occur 1 cycle after COMMIT is entered. That is 5 cycles after the `sl` rising edge at the pins.
- `miso` changes 4 cycles after an `spi_clk` falling pin edge. This leaves ≥4 cycles of setup before the master's next rising sample.
- An `sl` fall strobe in the same cycle as COMMIT/ABORT is honoured: counter clears and the FSM enters SHIFT on the next cycle.
- `rst` asserted mid-frame: everything returns to reset values next cycle. The in-flight frame is discarded and not counted.
- `sl` held low with no `spi_clk` edges: remain in SHIFT indefinitely.

## Configuration
- `SPI_SLV_READBACK_EN` defined: READ (0x02) is supported as described above.
- Undefined:
  - `miso` is tied to 0 and the output shift register is not built.
  - cmd 0x02 is treated as an invalid cmd and increments `err_cnt` at COMMIT.

## Test plan
- Reset, then WRITE cmd 0x01, addr 0x0012, data 0xBEEF → one `wr_valid` pulse with `wr_addr`=0x12, `wr_data`=0xBEEF; `err_cnt`=0.
- After the above, READ addr 0x0012 → `miso` bits 24–39 = 0xBEEF MSB first; `wr_valid` stays low. Without `SPI_SLV_READBACK_EN`: `miso` stays 0 and `err_cnt`=1.
- WRITE addr 0x0100 with ADDR_W=8 → no `wr_valid` pulse, `err_cnt` unchanged. Then READ 0x0100 → 0x0000.
- `sl` raised after 20 bits → no write; `err_cnt` +1. Cmd 0x7F as a full frame → `err_cnt` +1.
- 45 clocks in one frame (WRITE 0x0001, data 0x1234) → extra bits ignored; reg[1]=0x1234.
- `rst` pulsed at bit 30 of a WRITE → no `wr_valid`, `err_cnt`=0. The next full frame succeeds. `err_cnt` saturates at 0xFF after 260 aborts.
